ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter PC_W, default 16, giving the PC and instruction-memory address width.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 rst_f  input  1  reset, asynchronous and active-low.
REQ-005 ir_load  input  1  ctrl request to fetch the next instruction.
REQ-006 pc_write  input  1  ctrl strobe to update the PC.
REQ-007 pc_sel  input  1  with pc_write: 1 = load br_addr, 0 = increment.
REQ-008 br_addr  input  PC_W  branch target address.
REQ-009 imem_addr  output  PC_W  instruction-memory address; SHALL equal the PC.
REQ-010 imem_req  output  1  memory read request.
REQ-011 imem_ack  input  1  memory read completion; imem_data is valid in the same cycle.
REQ-012 imem_data  input  32  instruction word from memory.
REQ-013 instruction  output  32  instruction register (IR); feeds the sisc datapath.
REQ-014 ir_valid  output  1  the IR holds a completed fetch.
REQ-015 pc_out  output  PC_W  current PC.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and VALID, and SHALL be encoded in registers.
- IDLE -> FETCH when ir_load=1.
- FETCH -> VALID when imem_ack=1.
- VALID -> FETCH when ir_load=1.
- No other transitions.
REQ-017 imem_req SHALL be 1 exactly while the state is FETCH, as a registered Moore output.
REQ-018 On the edge that sees imem_ack=1 in FETCH, the module SHALL load the IR with imem_data and set ir_valid=1.
REQ-019 ir_valid SHALL be 1 exactly while the state is VALID.
- It SHALL clear on the edge that leaves VALID.
- The IR SHALL hold its last value until the next capture.
REQ-020 Latency: ir_load sampled at edge N SHALL give imem_req=1 after edge N.
- An imem_ack sampled at edge M SHALL update the IR after edge M.
- The minimum fetch time is 2 edges (ack asserted combinationally in the first FETCH cycle).
REQ-021 imem_ack sampled outside FETCH SHALL be ignored (no IR change, no state change).
REQ-022 ir_load sampled in FETCH SHALL be ignored and SHALL NOT be queued.
REQ-023 PC update on pc_write=1 outside FETCH:
- pc_sel=1 SHALL set PC <= br_addr.
- pc_sel=0 SHALL set PC <= PC+1, modulo 2^PC_W; all-ones wraps to 0.
REQ-024 pc_write=1 sampled in FETCH SHALL NOT change the PC immediately, so imem_addr stays stable while imem_req=1.
- The module SHALL latch the pending update (pc_sel, br_addr) and apply it on the edge that completes the fetch.
- A later pc_write in the same FETCH SHALL overwrite the pending update (last wins).
REQ-025 Simultaneous pc_write and ir_load in IDLE or VALID: the PC update SHALL take effect on the same edge.
- The new fetch SHALL then present the updated PC on imem_addr.
REQ-026 The pending-update flag SHALL clear when it is applied.

Reset
REQ-027 While rst_f=0, regardless of clk, the module SHALL force:
- state=IDLE, PC=RESET_PC, instruction=32'h0;
- ir_valid=0, imem_req=0;
- pending-update flag cleared.
REQ-028 Reset asserted during FETCH SHALL drop imem_req immediately and discard the in-flight fetch.
- An imem_ack arriving afterwards SHALL be ignored.
REQ-029 After rst_f rises, the first fetch SHALL start only on a sampled ir_load=1.

Verification
REQ-030 Reset then fetch: rst_f=0->1, ir_load pulse, memory acks 1 cycle later with 32'h1A2B3C4D.
- Required: imem_addr=0000, instruction=1A2B3C4D, ir_valid=1, back-to-back with no extra cycles.
REQ-031 Sequential run: 3x (pc_write=1, pc_sel=0, ir_load=1) with the memory returning addr+32'h100.
- Required: addresses 0001, 0002, 0003 and IR values 00000101, 00000102, 00000103.
REQ-032 Branch deferred: pc_write=1, pc_sel=1, br_addr=16'h0040 issued during a 3-cycle-wait FETCH at 0005.
- Required: imem_addr holds 0005 until ack, then PC=0040, and the next fetch addresses 0040.
REQ-033 Wrap: PC=FFFF, pc_write=1, pc_sel=0.
- Required: PC=0000 and no X on pc_out.
REQ-034 Mid-fetch reset: rst_f=0 one cycle after imem_req rises, with ack arriving 1 cycle later while reset is held.
- Required: imem_req=0 within the same cycle, IR stays 0, ir_valid=0, PC=RESET_PC.
REQ-035 Spurious inputs: imem_ack=1 in IDLE and VALID, and ir_load=1 in FETCH.
- Required: no IR or state change, and exactly one memory request per accepted ir_load.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues single-beat instruction-memory reads
// and holds the returned word in the IR for the datapath.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no fetch since reset; waiting for ir_load
// FETCH | imem_req asserted, imem_addr frozen; waiting for imem_ack
// VALID | IR holds a completed fetch; ir_load starts the next one
module ifetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            ir_load,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic [PC_W-1:0] br_addr,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instruction,
    output logic            ir_valid,
    output logic [PC_W-1:0] pc_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            pend_q, pend_d;
    logic            pend_sel_q, pend_sel_d;
    logic [PC_W-1:0] pend_addr_q, pend_addr_d;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= IDLE;
            pc_q        <= PC_W'(RESET_PC);
            ir_q        <= 32'h0;
            pend_q      <= 1'b0;
            pend_sel_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pend_q      <= pend_d;
            pend_sel_q  <= pend_sel_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        pend_d      = pend_q;
        pend_sel_d  = pend_sel_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            IDLE, VALID: begin
                if (pc_write) begin
                    pc_d = pc_sel ? br_addr : pc_q + PC_W'(1);
                end
                if (ir_load) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // PC must stay put while the read is outstanding; park the update.
                if (pc_write) begin
                    pend_d      = 1'b1;
                    pend_sel_d  = pc_sel;
                    pend_addr_d = br_addr;
                end
                if (imem_ack) begin
                    state_d = VALID;
                    ir_d    = imem_data;
                    if (pend_d) begin
                        pc_d = pend_sel_d ? pend_addr_d : pc_q + PC_W'(1);
                    end
                    pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instruction = ir_q;
    assign imem_req    = (state_q == FETCH);
    assign ir_valid    = (state_q == VALID);

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: vector table of fetches checked through an expected-result
// queue, plus hand sequences for deferred branch, wrap, spurious inputs and reset.
module tb_ifetch;

    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst_f;
    logic            ir_load = 1'b0;
    logic            pc_write = 1'b0;
    logic            pc_sel = 1'b0;
    logic [PC_W-1:0] br_addr = '0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack = 1'b0;
    logic [31:0]     imem_data = 32'h0;
    logic [31:0]     instruction;
    logic            ir_valid;
    logic [PC_W-1:0] pc_out;

    ifetch #(.RESET_PC(16'h0000), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .ir_load    (ir_load),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_addr    (br_addr),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instruction(instruction),
        .ir_valid   (ir_valid),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic        sel;
        logic [15:0] br;
        int          wait_c;
        logic        fixed;
        logic [15:0] exp_addr;
        logic [31:0] exp_ir;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] ir;
    } sb_t;

    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_loads = 0;
    int   req_count = 0;

    // memory model controls
    int          ack_wait = 0;
    logic        fixed_en = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] spur_data = 32'h0;
    int          wcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responds mid-low-phase so it always sees settled req and bench controls.
    always @(negedge clk) begin
        #1;
        if (spur_ack) begin
            imem_ack  = 1'b1;
            imem_data = spur_data;
        end else if (imem_req) begin
            if (wcnt == ack_wait) begin
                imem_ack  = 1'b1;
                imem_data = fixed_en ? 32'h1A2B3C4D : {16'h0, imem_addr} + 32'h100;
            end else begin
                imem_ack = 1'b0;
            end
            wcnt++;
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    logic [15:0] addr_seen = '0;
    logic        req_prev = 1'b0;
    logic        valid_prev = 1'b0;

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (imem_req && !req_prev) begin
            req_count++;
            addr_seen = imem_addr;
        end
        if (ir_valid && !valid_prev) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ir_valid: got ir=%h expected no completion", instruction);
            end else begin
                e = sb_q.pop_front();
                check("ir_data", instruction, e.ir);
                check("fetch_addr", {16'h0, addr_seen}, {16'h0, e.addr});
            end
        end
        req_prev   = imem_req;
        valid_prev = ir_valid;
    end

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = 0;
        while (cyc < maxc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ir_valid) break;
        end
    endtask

    task automatic fetch(input vec_t v);
        int cyc;
        @(negedge clk);
        pc_write = v.pw;
        pc_sel   = v.sel;
        br_addr  = v.br;
        ir_load  = 1'b1;
        ack_wait = v.wait_c;
        fixed_en = v.fixed;
        sb_q.push_back('{addr: v.exp_addr, ir: v.exp_ir});
        n_loads++;
        @(posedge clk);
        #1;
        check("req_after_load", {31'h0, imem_req}, 32'h1);
        check("valid_clears", {31'h0, ir_valid}, 32'h0);
        @(negedge clk);
        pc_write = 1'b0;
        ir_load  = 1'b0;
        wait_valid(30, cyc);
        check("latency", cyc + 1, v.wait_c + 2);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{pw:1'b0, sel:1'b0, br:16'h0000, wait_c:0, fixed:1'b1, exp_addr:16'h0000, exp_ir:32'h1A2B3C4D};
        vecs[1] = '{pw:1'b1, sel:1'b0, br:16'h0000, wait_c:0, fixed:1'b0, exp_addr:16'h0001, exp_ir:32'h00000101};
        vecs[2] = '{pw:1'b1, sel:1'b0, br:16'h0000, wait_c:1, fixed:1'b0, exp_addr:16'h0002, exp_ir:32'h00000102};
        vecs[3] = '{pw:1'b1, sel:1'b0, br:16'h0000, wait_c:2, fixed:1'b0, exp_addr:16'h0003, exp_ir:32'h00000103};
        vecs[4] = '{pw:1'b1, sel:1'b1, br:16'h1234, wait_c:0, fixed:1'b0, exp_addr:16'h1234, exp_ir:32'h00001334};
        vecs[5] = '{pw:1'b0, sel:1'b0, br:16'hBEEF, wait_c:1, fixed:1'b0, exp_addr:16'h1234, exp_ir:32'h00001334};

        rst_f = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_ir", instruction, 32'h0);
        check("rst_pc", {16'h0, pc_out}, 32'h0);
        @(negedge clk);
        rst_f = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_req", {31'h0, imem_req}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i]);
        end

        // deferred branch with last-wins pending update
        fetch('{pw:1'b1, sel:1'b1, br:16'h0005, wait_c:0, fixed:1'b0, exp_addr:16'h0005, exp_ir:32'h00000105});
        @(negedge clk);
        ir_load  = 1'b1;
        ack_wait = 3;
        sb_q.push_back('{addr: 16'h0005, ir: 32'h00000105});
        n_loads++;
        @(posedge clk);
        #1;
        check("defer_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        ir_load  = 1'b0;
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_addr  = 16'h0077;
        @(posedge clk);
        #1;
        check("defer_addr_hold1", {16'h0, imem_addr}, 32'h0005);
        @(negedge clk);
        br_addr = 16'h0040;
        @(posedge clk);
        #1;
        check("defer_addr_hold2", {16'h0, imem_addr}, 32'h0005);
        @(negedge clk);
        pc_write = 1'b0;
        @(posedge clk);
        #1;
        check("defer_addr_hold3", {16'h0, imem_addr}, 32'h0005);
        check("defer_req_hold", {31'h0, imem_req}, 32'h1);
        wait_valid(10, cyc);
        check("defer_done_cycles", cyc, 1);
        check("defer_pc_applied", {16'h0, pc_out}, 32'h0040);
        fetch('{pw:1'b0, sel:1'b0, br:16'h0000, wait_c:0, fixed:1'b0, exp_addr:16'h0040, exp_ir:32'h00000140});
        fetch('{pw:1'b1, sel:1'b0, br:16'h0000, wait_c:0, fixed:1'b0, exp_addr:16'h0041, exp_ir:32'h00000141});
        check("pend_cleared_pc", {16'h0, pc_out}, 32'h0041);

        // wrap from all-ones
        @(negedge clk);
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_addr  = 16'hFFFF;
        @(posedge clk);
        #1;
        check("load_ffff", {16'h0, pc_out}, 32'hFFFF);
        @(negedge clk);
        pc_sel = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_pc", {16'h0, pc_out}, 32'h0000);
        check("wrap_no_x", {31'h0, $isunknown(pc_out)}, 32'h0);
        @(negedge clk);
        pc_write = 1'b0;
        fetch('{pw:1'b0, sel:1'b0, br:16'h0000, wait_c:1, fixed:1'b0, exp_addr:16'h0000, exp_ir:32'h00000100});

        // spurious ack in VALID
        @(negedge clk);
        spur_ack  = 1'b1;
        spur_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check("spur_valid_ir", instruction, 32'h00000100);
        check("spur_valid_state", {30'h0, imem_req, ir_valid}, 32'h1);
        @(negedge clk);
        spur_ack = 1'b0;

        // ir_load held through FETCH must not queue a second fetch
        @(negedge clk);
        ir_load  = 1'b1;
        ack_wait = 3;
        sb_q.push_back('{addr: 16'h0000, ir: 32'h00000100});
        n_loads++;
        @(posedge clk);
        #1;
        check("spur_load_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        ir_load = 1'b0;
        wait_valid(10, cyc);
        check("spur_load_valid", {31'h0, ir_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_queued_fetch", {30'h0, imem_req, ir_valid}, 32'h1);
        end
        check("one_req_per_load", req_count, n_loads);

        // reset during FETCH, late ack under reset
        @(negedge clk);
        ir_load  = 1'b1;
        ack_wait = 7;
        n_loads++;
        @(posedge clk);
        @(negedge clk);
        ir_load = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        rst_f = 1'b0;
        #1;
        check("reset_drops_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        spur_ack  = 1'b1;
        spur_data = 32'h12345678;
        @(posedge clk);
        #1;
        check("mid_rst_ir", instruction, 32'h0);
        check("mid_rst_valid", {31'h0, ir_valid}, 32'h0);
        check("mid_rst_pc", {16'h0, pc_out}, 32'h0);
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        spur_ack = 1'b0;
        rst_f    = 1'b1;

        // spurious ack in IDLE, then no fetch without ir_load
        @(negedge clk);
        spur_ack  = 1'b1;
        spur_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("spur_idle_ir", instruction, 32'h0);
        check("spur_idle_state", {30'h0, imem_req, ir_valid}, 32'h0);
        @(negedge clk);
        spur_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_waits_load", {31'h0, imem_req}, 32'h0);
        end
        fetch('{pw:1'b0, sel:1'b0, br:16'h0000, wait_c:0, fixed:1'b0, exp_addr:16'h0000, exp_ir:32'h00000100});
        check("final_req_count", req_count, n_loads);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
